// File: rtl/ecc_apb_pkg.sv
// Shared definitions for the ECC APB master: register map, opcodes, width codes, FSM encoding.
// Readback states exist only when ECC_APB_READBACK_EN is defined.
package ecc_apb_pkg;

  localparam logic [3:0] CTRL_OFF           = 4'h0;
  localparam logic [3:0] DATA_IN_OFF        = 4'h4;
  localparam logic [3:0] CODEWORD_WIDTH_OFF = 4'h8;
  localparam logic [3:0] NOISE_OFF          = 4'hC;

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FULL = 2'b10;

  localparam logic [1:0] W_SMALL  = 2'b00;
  localparam logic [1:0] W_MEDIUM = 2'b01;
  localparam logic [1:0] W_LARGE  = 2'b10;

  // CTRL is the final write of the sequence because writing it starts the slave.
  localparam logic [1:0] SEQ_LAST = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
`ifdef ECC_APB_READBACK_EN
    ,
    ST_RB_SETUP  = 3'd5,
    ST_RB_ACCESS = 3'd6
`endif
  } state_t;

  function automatic logic [3:0] reg_off(input logic [1:0] seq);
    case (seq)
      2'd0:    reg_off = CODEWORD_WIDTH_OFF;
      2'd1:    reg_off = DATA_IN_OFF;
      2'd2:    reg_off = NOISE_OFF;
      default: reg_off = CTRL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_master_apb_xfer.sv
// Single APB SETUP/ACCESS sequencer; i_start loads address/data and begins a transfer next cycle.
// A start presented during ACCESS chains the next transfer with no idle cycle in between.
module apb_xfer #(
  parameter int AW = 20,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_write,
  output logic [AW-1:0] o_paddr,
  output logic [DW-1:0] o_pwdata,
  output logic          o_psel,
  output logic          o_penable,
  output logic          o_pwrite
);

  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic          r_psel;
  logic          r_penable;
  logic          r_pwrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
    end else if (i_start) begin
      r_paddr   <= i_addr;
      r_pwdata  <= i_wdata;
      r_pwrite  <= i_write;
      r_psel    <= 1'b1;
      r_penable <= 1'b0;
    end else if (r_psel && !r_penable) begin
      r_penable <= 1'b1;
    end else begin
      // Address/data are left as-is; only the strobes drop.
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end
  end

  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_pwrite;

endmodule

// File: rtl/ecc_apb_master.sv
// Command-driven APB master programming an ECC slave and waiting for op_done with a timeout.
// Optional DATA_IN readback check enabled by ECC_APB_READBACK_EN.
module ecc_apb_master
  import ecc_apb_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BASE_ADDR       = 0,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_width,
  input  logic [AMBA_WORD-1:0]       cmd_data,
  input  logic [AMBA_WORD-1:0]       cmd_noise,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_errors,
  output logic                       rsp_timeout,
  output logic                       rsp_rb_err,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic [DATA_WIDTH-1:0]      ecc_data_out,
  input  logic                       ecc_op_done,
  input  logic [1:0]                 ecc_num_errors
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  // Terminal count is detected one cycle early so the counter reaches
  // TIMEOUT_CYCLES-1 on the same edge that enters RESP.
  localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TIMEOUT_CYCLES - 2);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_seq;
  logic [TMO_W-1:0]      r_tmo;
  logic [1:0]            r_op;
  logic [1:0]            r_width;
  logic [AMBA_WORD-1:0]  r_data;
  logic [AMBA_WORD-1:0]  r_noise;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_errors;
  logic                  r_rsp_timeout;

  logic                       w_accept;
  logic                       w_start;
  logic                       w_xfer_write;
  logic [1:0]                 w_wr_seq;
  logic [AMBA_ADDR_WIDTH-1:0] w_xfer_addr;
  logic [AMBA_WORD-1:0]       w_xfer_wdata;
  logic                       w_tmo_term;

  assign cmd_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_tmo_term = (r_tmo == TMO_TERM);
  assign w_wr_seq   = (r_state == ST_IDLE) ? 2'd0 : (r_seq + 2'd1);

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_xfer_write = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_start = 1'b1;
          w_next  = ST_SETUP;
        end
      end
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (r_seq != SEQ_LAST) begin
          w_start = 1'b1;
          w_next  = ST_SETUP;
        end else begin
`ifdef ECC_APB_READBACK_EN
          w_start      = 1'b1;
          w_xfer_write = 1'b0;
          w_next       = ST_RB_SETUP;
`else
          w_next = ST_WAIT_DONE;
`endif
        end
      end
`ifdef ECC_APB_READBACK_EN
      ST_RB_SETUP:  w_next = ST_RB_ACCESS;
      ST_RB_ACCESS: w_next = ST_WAIT_DONE;
`endif
      ST_WAIT_DONE: begin
        if (ecc_op_done || w_tmo_term) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The first write leaves IDLE on the accepting edge, before cmd_width is registered.
  always_comb begin
    w_xfer_wdata = '0;
    case (w_wr_seq)
      2'd0:    w_xfer_wdata = AMBA_WORD'(cmd_width);
      2'd1:    w_xfer_wdata = r_data;
      2'd2:    w_xfer_wdata = r_noise;
      default: w_xfer_wdata = AMBA_WORD'(r_op);
    endcase
    w_xfer_addr = AMBA_ADDR_WIDTH'(BASE_ADDR) + AMBA_ADDR_WIDTH'(reg_off(w_wr_seq));
    if (!w_xfer_write) begin
      w_xfer_addr  = AMBA_ADDR_WIDTH'(BASE_ADDR) + AMBA_ADDR_WIDTH'(DATA_IN_OFF);
      w_xfer_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_seq         <= '0;
      r_tmo         <= '0;
      r_op          <= '0;
      r_width       <= '0;
      r_data        <= '0;
      r_noise       <= '0;
      r_rsp_data    <= '0;
      r_rsp_errors  <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= cmd_op;
        r_width <= cmd_width;
        r_data  <= cmd_data;
        r_noise <= cmd_noise;
        r_seq   <= '0;
      end else if (r_state == ST_ACCESS) begin
        r_seq <= r_seq + 2'd1;
      end
      if (r_state == ST_WAIT_DONE) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end else begin
        r_tmo <= '0;
      end
      if (r_state == ST_WAIT_DONE) begin
        if (ecc_op_done) begin
          r_rsp_data    <= ecc_data_out;
          r_rsp_errors  <= ecc_num_errors;
          r_rsp_timeout <= 1'b0;
        end else if (w_tmo_term) begin
          r_rsp_data    <= '0;
          r_rsp_errors  <= '0;
          r_rsp_timeout <= 1'b1;
        end
      end
    end
  end

`ifdef ECC_APB_READBACK_EN
  logic r_rb_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rb_err <= 1'b0;
    end else if (r_state == ST_RB_ACCESS) begin
      r_rb_err <= (PRDATA != r_data);
    end
  end

  assign rsp_rb_err = r_rb_err;
`else
  logic w_unused_prdata;
  assign w_unused_prdata = ^PRDATA;
  assign rsp_rb_err      = 1'b0;
`endif

  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_errors  = r_rsp_errors;
  assign rsp_timeout = r_rsp_timeout;

  apb_xfer #(
    .AW (AMBA_ADDR_WIDTH),
    .DW (AMBA_WORD)
  ) u_apb_xfer (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_addr    (w_xfer_addr),
    .i_wdata   (w_xfer_wdata),
    .i_write   (w_xfer_write),
    .o_paddr   (PADDR),
    .o_pwdata  (PWDATA),
    .o_psel    (PSEL),
    .o_penable (PENABLE),
    .o_pwrite  (PWRITE)
  );

endmodule

// File: tb/tb_ecc_apb_master.sv
// Directed bench for ecc_apb_master; expectations adjust when ECC_APB_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_ecc_apb_master;
  import ecc_apb_pkg::*;

  localparam int T = 64;
`ifdef ECC_APB_READBACK_EN
  localparam int RB    = 2;
  localparam bit RB_ON = 1'b1;
`else
  localparam int RB    = 0;
  localparam bit RB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_width = 2'b00;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_noise = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_errors;
  logic        rsp_timeout;
  logic        rsp_rb_err;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PRDATA = 32'h0000_DEAD;
  logic [31:0] ecc_data_out = '0;
  logic        ecc_op_done = 1'b0;
  logic [1:0]  ecc_num_errors = 2'b00;

  ecc_apb_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_width(cmd_width), .cmd_data(cmd_data), .cmd_noise(cmd_noise),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_errors(rsp_errors), .rsp_timeout(rsp_timeout), .rsp_rb_err(rsp_rb_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRDATA(PRDATA), .ecc_data_out(ecc_data_out), .ecc_op_done(ecc_op_done),
    .ecc_num_errors(ecc_num_errors)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observations recorded by run_cmd, one entry per APB ACCESS / SETUP cycle.
  logic [19:0] log_addr [8];
  logic [31:0] log_data [8];
  logic        log_wr   [8];
  int          log_cyc  [8];
  logic [19:0] set_addr [8];
  logic [31:0] set_data [8];
  int nlog, nset, acc_cyc, rsp_cyc, last_acc;
  bit got_rsp, accepted;

  // Issues one command, plays the slave (op_done 'delay' cycles after the last
  // APB access, never if negative) and stops at rsp_valid. No comparisons here.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] w, input logic [31:0] d,
                         input logic [31:0] n, input int delay, input logic [31:0] dout,
                         input logic [1:0] nerr);
    nlog = 0; nset = 0; got_rsp = 0; rsp_cyc = -1; last_acc = -1;
    cmd_op = op; cmd_width = w; cmd_data = d; cmd_noise = n; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) begin
      @(posedge clk); @(negedge clk);
    end
    accepted = cmd_ready;
    @(posedge clk); @(negedge clk);
    acc_cyc = cyc; cmd_valid = 1'b0;
    ecc_data_out = dout; ecc_num_errors = nerr;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid) begin
        got_rsp = 1; rsp_cyc = cyc;
        break;
      end
      if (PSEL && !PENABLE && nset < 8) begin
        set_addr[nset] = PADDR; set_data[nset] = PWDATA; nset++;
      end
      if (PSEL && PENABLE && nlog < 8) begin
        log_addr[nlog] = PADDR; log_data[nlog] = PWDATA; log_wr[nlog] = PWRITE;
        log_cyc[nlog] = cyc; last_acc = cyc; nlog++;
      end
      ecc_op_done = (delay >= 0 && last_acc >= 0 && cyc == last_acc + delay);
      @(posedge clk); @(negedge clk);
    end
    ecc_op_done = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin failures++; $display("FAIL rst_apb_ctl: got %b want 000", {PSEL, PENABLE, PWRITE}); end
    checks++; if (PADDR !== 20'h0 || PWDATA !== 32'h0) begin failures++; $display("FAIL rst_apb_bus: got %h/%h want 0/0", PADDR, PWDATA); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_rb_err} !== 3'b000) begin failures++; $display("FAIL rst_rsp_flags: got %b want 000", {rsp_valid, rsp_timeout, rsp_rb_err}); end
    checks++; if (rsp_data !== 32'h0 || rsp_errors !== 2'b00) begin failures++; $display("FAIL rst_rsp_data: got %h/%b want 0/00", rsp_data, rsp_errors); end
    cmd_valid = 1'b0; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_encode_small();
    logic [19:0] ea [4];
    logic [31:0] ed [4];
    ea = '{20'h8, 20'h4, 20'hC, 20'h0};
    ed = '{32'h0, 32'h5, 32'h0, 32'h0};
    run_cmd(OP_ENC, W_SMALL, 32'h5, 32'h0, 2, 32'h2D, 2'b00);
    checks++; if (accepted !== 1'b1) begin failures++; $display("FAIL enc_accept: got %b want 1", accepted); end
    checks++; if (nlog !== 4 + RB / 2) begin failures++; $display("FAIL enc_nxfer: got %0d want %0d", nlog, 4 + RB / 2); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_wr[i] !== 1'b1) begin
        failures++; $display("FAIL enc_write%0d: got %h<-%h w%b want %h<-%h w1", i, log_addr[i], log_data[i], log_wr[i], ea[i], ed[i]);
      end
      checks++; if (set_addr[i] !== ea[i] || set_data[i] !== ed[i]) begin
        failures++; $display("FAIL enc_setup%0d: got %h<-%h want %h<-%h", i, set_addr[i], set_data[i], ea[i], ed[i]);
      end
      checks++; if (log_cyc[i] - acc_cyc !== 1 + 2 * i) begin
        failures++; $display("FAIL enc_timing%0d: got %0d want %0d", i, log_cyc[i] - acc_cyc, 1 + 2 * i);
      end
    end
    if (RB_ON) begin
      checks++; if (log_addr[4] !== 20'h4 || log_wr[4] !== 1'b0 || log_cyc[4] - acc_cyc !== 9) begin
        failures++; $display("FAIL enc_readback: got %h w%b at %0d want 4 w0 at 9", log_addr[4], log_wr[4], log_cyc[4] - acc_cyc);
      end
    end
    checks++; if (got_rsp !== 1'b1 || rsp_cyc - acc_cyc !== 10 + RB) begin failures++; $display("FAIL enc_latency: got %b/%0d want 1/%0d", got_rsp, rsp_cyc - acc_cyc, 10 + RB); end
    checks++; if (rsp_data !== 32'h2D || rsp_errors !== 2'b00) begin failures++; $display("FAIL enc_rsp: got %h/%b want 2d/00", rsp_data, rsp_errors); end
    checks++; if (rsp_timeout !== 1'b0 || rsp_rb_err !== RB_ON) begin failures++; $display("FAIL enc_flags: got %b%b want 0%b", rsp_timeout, rsp_rb_err, RB_ON); end
    finish_rsp();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL enc_release: got %b%b want 01", rsp_valid, cmd_ready); end
  endtask

  task automatic test_full_noise();
    run_cmd(OP_FULL, W_SMALL, 32'h5, 32'h4, 3, 32'h2D, 2'b01);
    checks++; if (log_data[2] !== 32'h4 || log_data[3] !== 32'h2) begin failures++; $display("FAIL full_writes: got %h/%h want 4/2", log_data[2], log_data[3]); end
    checks++; if (got_rsp !== 1'b1 || rsp_cyc - last_acc !== 4) begin failures++; $display("FAIL full_latency: got %b/%0d want 1/4", got_rsp, rsp_cyc - last_acc); end
    checks++; if (rsp_errors !== 2'b01 || rsp_timeout !== 1'b0) begin failures++; $display("FAIL full_rsp: got %b/%b want 01/0", rsp_errors, rsp_timeout); end
    checks++; if (rsp_data !== 32'h2D) begin failures++; $display("FAIL full_data: got %h want 2d", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_timeout();
    run_cmd(OP_DEC, W_MEDIUM, 32'h1234, 32'h0, -1, 32'hFFFF, 2'b11);
    checks++; if (log_data[0] !== 32'h1 || log_data[3] !== 32'h1) begin failures++; $display("FAIL tmo_writes: got %h/%h want 1/1", log_data[0], log_data[3]); end
    checks++; if (got_rsp !== 1'b1 || rsp_cyc - log_cyc[3] !== T + RB) begin failures++; $display("FAIL tmo_latency: got %b/%0d want 1/%0d", got_rsp, rsp_cyc - log_cyc[3], T + RB); end
    checks++; if (rsp_timeout !== 1'b1) begin failures++; $display("FAIL tmo_flag: got %b want 1", rsp_timeout); end
    checks++; if (rsp_data !== 32'h0 || rsp_errors !== 2'b00) begin failures++; $display("FAIL tmo_data: got %h/%b want 0/00", rsp_data, rsp_errors); end
    checks++; if (rsp_rb_err !== RB_ON) begin failures++; $display("FAIL tmo_rb: got %b want %b", rsp_rb_err, RB_ON); end
    finish_rsp();
  endtask

  task automatic test_done_at_terminal();
    run_cmd(OP_ENC, W_LARGE, 32'h7, 32'h0, T - 1, 32'hABCD, 2'b00);
    checks++; if (got_rsp !== 1'b1 || rsp_cyc - last_acc !== T) begin failures++; $display("FAIL tie_latency: got %b/%0d want 1/%0d", got_rsp, rsp_cyc - last_acc, T); end
    checks++; if (rsp_timeout !== 1'b0 || rsp_data !== 32'hABCD) begin failures++; $display("FAIL tie_rsp: got %b/%h want 0/abcd", rsp_timeout, rsp_data); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    run_cmd(OP_DEC, W_SMALL, 32'h0000_DEAD, 32'h1, 2, 32'h55, 2'b10);
    checks++; if (got_rsp !== 1'b1 || rsp_rb_err !== 1'b0) begin failures++; $display("FAIL bp_rsp: got %b/%b want 1/0", got_rsp, rsp_rb_err); end
    cmd_op = OP_ENC; cmd_width = W_LARGE; cmd_data = 32'h9; cmd_noise = 32'h0; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || rsp_errors !== 2'b10 || rsp_timeout !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d: got %b %h %b %b want 1 55 10 0", i, rsp_valid, rsp_data, rsp_errors, rsp_timeout);
      end
      checks++; if (cmd_ready !== 1'b0 || PSEL !== 1'b0) begin failures++; $display("FAIL bp_quiet%0d: got %b%b want 00", i, cmd_ready, PSEL); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got %b%b want 01", rsp_valid, cmd_ready); end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 20'h8 || PWDATA !== 32'h2) begin
      failures++; $display("FAIL bp_next_cmd: got %b %h %h want 10 8 2", {PSEL, PENABLE}, PADDR, PWDATA);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    cmd_op = OP_FULL; cmd_width = W_SMALL; cmd_data = 32'h3; cmd_noise = 32'h1; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    checks++; if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 20'hC) begin failures++; $display("FAIL mid_noise_access: got %b %h want 11 c", {PSEL, PENABLE}, PADDR); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin failures++; $display("FAIL mid_abort: got %b want 0000", {PSEL, PENABLE, rsp_valid, cmd_ready}); end
    rst = 1'b0; ecc_op_done = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    ecc_op_done = 1'b0;
    checks++; if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin failures++; $display("FAIL mid_idle: got %b want 001", {PSEL, rsp_valid, cmd_ready}); end
  endtask

  initial begin
    test_reset();
    test_encode_small();
    test_full_noise();
    test_timeout();
    test_done_at_terminal();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
